r_peak_ctrl: RTL and testbench

- Sequencing controller for the R-peak detection path.
- Consumes the 9-bit offset-binary derivative stream, one word per sample strobe, centred at MID.
- Owns the adaptive band thresholds (vth_p/vth_n) and re-configures them after every confirmed beat.
- Runs the arm / peak-track / refractory state machine and measures RR intervals in samples for downstream heart-rate logic.

---
 rtl/r_peak_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_r_peak_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/r_peak_ctrl.sv
// -----------------------------------------------------------------------------
// r_peak_ctrl
// Sequencing controller for the R-peak detection path. Consumes an offset-
// binary derivative stream (zero at MID), keeps the adaptive band thresholds,
// runs the arm / peak-track / refractory state machine and measures RR
// intervals in samples.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   en           detection enable (level); low forces IDLE
//   sample_valid one-cycle strobe per derivative sample
//   diff_in      derivative sample, offset binary around MID
//   vth_p/vth_n  registered band thresholds MID+th / MID-th
//   beat         one-cycle pulse per confirmed R peak
//   rr_interval  samples between the last two beats (held)
//   rr_valid     one-cycle pulse with beat when rr_interval is new
//   timeout      one-cycle pulse when no beat is seen for RR_MAX samples
//   peak_mag     magnitude of the last confirmed peak (held)
//   state        IDLE=0, ARMED=1, PEAK=2, REFRACT=3
// -----------------------------------------------------------------------------
module r_peak_ctrl #(
    parameter int unsigned DW      = 9,
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned MID     = 256,
    parameter int unsigned TH_INIT = 8,
    parameter int unsigned TH_MIN  = 4,
    parameter int unsigned REFRACT = 50,
    parameter int unsigned RR_MAX  = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sample_valid,
    input  logic [DW-1:0]    diff_in,
    output logic [DW-1:0]    vth_p,
    output logic [DW-1:0]    vth_n,
    output logic             beat,
    output logic [CNT_W-1:0] rr_interval,
    output logic             rr_valid,
    output logic             timeout,
    output logic [7:0]       peak_mag,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PEAK  = 2'd2,
        ST_REFR  = 2'd3
    } state_e;

    localparam int unsigned   RW        = $clog2(REFRACT + 1);
    localparam logic [DW-1:0] MID_V     = DW'(MID);
    localparam logic [DW-1:0] TH_INIT_V = DW'(TH_INIT);
    localparam logic [DW-1:0] TH_MIN_V  = DW'(TH_MIN);
    localparam logic [RW-1:0] REFR_LAST = RW'(REFRACT - 1);
    localparam logic [CNT_W:0] RR_MAX_V = (CNT_W + 1)'(RR_MAX);

    state_e           state_q, state_d;
    logic [DW-1:0]    th_q, th_d;
    logic [7:0]       trk_q, trk_d;
    logic [RW-1:0]    refr_q, refr_d;
    logic [CNT_W-1:0] rr_cnt_q, rr_cnt_d;
    logic             first_q, first_d;
    logic             beat_q, beat_d;
    logic             rr_valid_q, rr_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] rr_interval_q, rr_interval_d;
    logic [7:0]       peak_mag_q, peak_mag_d;
    logic [DW-1:0]    vth_p_q, vth_n_q;

    // Magnitude of the excursion from MID; only diff_in=0 reaches 256.
    logic [DW-1:0]    dev;
    logic [7:0]       mag;
    logic             above;
    logic [DW-1:0]    th_mix, th_adapt;
    logic [CNT_W-1:0] rr_inc;
    logic             rr_hit;
    logic [7:0]       trk_max;

    assign dev      = (diff_in >= MID_V) ? (diff_in - MID_V) : (MID_V - diff_in);
    assign mag      = (dev > DW'(255)) ? 8'hFF : dev[7:0];
    assign above    = DW'(mag) > th_q;
    assign trk_max  = (mag > trk_q) ? mag : trk_q;

    // th + trk/2 stays below 255, so the sum never overflows DW bits.
    assign th_mix   = (th_q + DW'(trk_q >> 1)) >> 1;
    assign th_adapt = (th_mix < TH_MIN_V) ? TH_MIN_V : th_mix;

    assign rr_inc   = (rr_cnt_q == '1) ? rr_cnt_q : rr_cnt_q + CNT_W'(1);
    assign rr_hit   = ({1'b0, rr_cnt_q} + (CNT_W + 1)'(1)) == RR_MAX_V;

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        th_d          = th_q;
        trk_d         = trk_q;
        refr_d        = refr_q;
        rr_cnt_d      = rr_cnt_q;
        first_d       = first_q;
        beat_d        = 1'b0;
        rr_valid_d    = 1'b0;
        timeout_d     = 1'b0;
        rr_interval_d = rr_interval_q;
        peak_mag_d    = peak_mag_q;

        if (!en) begin
            // Disable wins over everything, including a commit on this strobe.
            state_d  = ST_IDLE;
            trk_d    = '0;
            refr_d   = '0;
            rr_cnt_d = '0;
            first_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_ARMED;

                ST_ARMED: if (sample_valid) begin
                    if (rr_hit) begin
                        timeout_d = 1'b1;
                        th_d      = TH_INIT_V;
                        rr_cnt_d  = '0;
                        first_d   = 1'b1;
                    end else begin
                        rr_cnt_d = rr_inc;
                        if (above) begin
                            state_d = ST_PEAK;
                            trk_d   = mag;
                        end
                    end
                end

                ST_PEAK: if (sample_valid) begin
                    if (!above) begin
                        // Commit: a commit never raises timeout, even at RR_MAX.
                        state_d    = ST_REFR;
                        refr_d     = '0;
                        beat_d     = 1'b1;
                        peak_mag_d = trk_q;
                        th_d       = th_adapt;
                        rr_cnt_d   = '0;
                        first_d    = 1'b0;
                        if (!first_q) begin
                            rr_interval_d = rr_inc;
                            rr_valid_d    = 1'b1;
                        end
                    end else begin
                        trk_d    = trk_max;
                        rr_cnt_d = rr_inc;
                    end
                end

                ST_REFR: if (sample_valid) begin
                    rr_cnt_d = rr_inc;
                    if (refr_q == REFR_LAST) begin
                        state_d = ST_ARMED;
                        refr_d  = '0;
                    end else begin
                        refr_d = refr_q + RW'(1);
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            th_q          <= TH_INIT_V;
            trk_q         <= '0;
            refr_q        <= '0;
            rr_cnt_q      <= '0;
            first_q       <= 1'b1;
            beat_q        <= 1'b0;
            rr_valid_q    <= 1'b0;
            timeout_q     <= 1'b0;
            rr_interval_q <= '0;
            peak_mag_q    <= '0;
            vth_p_q       <= MID_V + TH_INIT_V;
            vth_n_q       <= MID_V - TH_INIT_V;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            th_q          <= th_d;
            trk_q         <= trk_d;
            refr_q        <= refr_d;
            rr_cnt_q      <= rr_cnt_d;
            first_q       <= first_d;
            beat_q        <= beat_d;
            rr_valid_q    <= rr_valid_d;
            timeout_q     <= timeout_d;
            rr_interval_q <= rr_interval_d;
            peak_mag_q    <= peak_mag_d;
            vth_p_q       <= MID_V + th_d;
            vth_n_q       <= MID_V - th_d;
        end
    end

    assign vth_p       = vth_p_q;
    assign vth_n       = vth_n_q;
    assign beat        = beat_q;
    assign rr_valid    = rr_valid_q;
    assign timeout     = timeout_q;
    assign rr_interval = rr_interval_q;
    assign peak_mag    = peak_mag_q;
    assign state       = state_q;

endmodule

// File: tb/tb_r_peak_ctrl.sv
// -----------------------------------------------------------------------------
// tb_r_peak_ctrl
// Directed bench for r_peak_ctrl. The stimulus process queues the expected
// beat/timeout events just before the strobe that should cause them; a
// monitor pops and compares whenever the DUT pulses beat or timeout.
// -----------------------------------------------------------------------------
module tb_r_peak_ctrl;

    localparam int DW    = 9;
    localparam int CNT_W = 12;

    localparam int S_IDLE  = 0;
    localparam int S_ARMED = 1;
    localparam int S_PEAK  = 2;
    localparam int S_REFR  = 3;

    logic             clk;
    logic             rst;
    logic             en;
    logic             sample_valid;
    logic [DW-1:0]    diff_in;
    logic [DW-1:0]    vth_p;
    logic [DW-1:0]    vth_n;
    logic             beat;
    logic [CNT_W-1:0] rr_interval;
    logic             rr_valid;
    logic             timeout;
    logic [7:0]       peak_mag;
    logic [1:0]       state;

    r_peak_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_valid (sample_valid),
        .diff_in      (diff_in),
        .vth_p        (vth_p),
        .vth_n        (vth_n),
        .beat         (beat),
        .rr_interval  (rr_interval),
        .rr_valid     (rr_valid),
        .timeout      (timeout),
        .peak_mag     (peak_mag),
        .state        (state)
    );

    typedef struct {
        bit is_timeout;
        int peak_mag;
        int vth_p;
        int vth_n;
        bit rr_valid;
        int rr_interval;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic expect_evt(input bit to, input int pm, input int vp, input int vn,
                              input bit rv, input int rri);
        exp_t e;
        e.is_timeout  = to;
        e.peak_mag    = pm;
        e.vth_p       = vp;
        e.vth_n       = vn;
        e.rr_valid    = rv;
        e.rr_interval = rri;
        exp_q.push_back(e);
    endtask

    // One strobe; called at a falling edge, returns at the next falling edge
    // with the DUT's response to that strobe visible.
    task automatic strobe(input int v);
        sample_valid = 1'b1;
        diff_in      = DW'(v);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic flat(input int n);
        for (int i = 0; i < n; i++) strobe(256);
    endtask

    // Monitor: compares every beat/timeout pulse against the queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (rr_valid && !beat) check("rr_valid_without_beat", 1, 0);
            if (beat || timeout) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", int'({beat, timeout}), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("evt_timeout",     int'(timeout),     int'(mon_e.is_timeout));
                    check("evt_beat",        int'(beat),        int'(!mon_e.is_timeout));
                    check("evt_peak_mag",    int'(peak_mag),    mon_e.peak_mag);
                    check("evt_vth_p",       int'(vth_p),       mon_e.vth_p);
                    check("evt_vth_n",       int'(vth_n),       mon_e.vth_n);
                    check("evt_rr_valid",    int'(rr_valid),    int'(mon_e.rr_valid));
                    check("evt_rr_interval", int'(rr_interval), mon_e.rr_interval);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        en           = 1'b0;
        sample_valid = 1'b0;
        diff_in      = DW'(256);
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_state",       int'(state),       S_IDLE);
        check("rst_vth_p",       int'(vth_p),       264);
        check("rst_vth_n",       int'(vth_n),       248);
        check("rst_beat",        int'(beat),        0);
        check("rst_timeout",     int'(timeout),     0);
        check("rst_rr_interval", int'(rr_interval), 0);
        check("rst_peak_mag",    int'(peak_mag),    0);

        rst = 1'b1;
        @(negedge clk);
        check("idle_while_disabled", int'(state), S_IDLE);
        en = 1'b1;
        @(negedge clk);
        check("armed_after_en", int'(state), S_ARMED);

        // Flat input: no beat, thresholds untouched
        flat(100);
        check("flat_state", int'(state), S_ARMED);
        check("flat_vth_p", int'(vth_p), 264);
        check("flat_vth_n", int'(vth_n), 248);

        // Single peak: th 8 -> (8+22)>>1 = 15
        strobe(256);
        check("pk1_armed", int'(state), S_ARMED);
        strobe(270);
        check("pk1_enter_peak", int'(state), S_PEAK);
        strobe(300);
        strobe(280);
        check("pk1_still_peak", int'(state), S_PEAK);
        expect_evt(1'b0, 44, 271, 241, 1'b0, 0);
        strobe(260);
        check("pk1_refract", int'(state), S_REFR);

        // Refractory: excursion 10 samples after commit is ignored; 50 samples total
        flat(9);
        strobe(300);
        check("refr_ignore_excursion", int'(state), S_REFR);
        flat(39);
        check("refr_sample49", int'(state), S_REFR);
        flat(1);
        check("refr_sample50_armed", int'(state), S_ARMED);

        // Second peak committing on the 200th strobe after the first commit;
        // th 15 -> (15+22)>>1 = 18
        flat(147);
        strobe(300);
        strobe(280);
        expect_evt(1'b0, 44, 274, 238, 1'b1, 200);
        strobe(260);

        // Timeout on the 4095th strobe after the commit
        flat(4094);
        check("pre_timeout_state", int'(state), S_ARMED);
        expect_evt(1'b1, 44, 264, 248, 1'b0, 200);
        strobe(256);
        #1;
        check("timeout_seen", exp_q.size(), 0);
        check("timeout_state", int'(state), S_ARMED);
        check("timeout_vth_p", int'(vth_p), 264);

        // Small peaks walking th down: 8 -> 6 -> 4 -> clamp at 4
        strobe(265);
        check("small1_peak", int'(state), S_PEAK);
        expect_evt(1'b0, 9, 262, 250, 1'b0, 200);   // first beat after timeout
        strobe(256);
        flat(50);
        strobe(263);
        expect_evt(1'b0, 7, 260, 252, 1'b1, 52);
        strobe(256);
        flat(50);
        strobe(261);
        expect_evt(1'b0, 5, 260, 252, 1'b1, 52);    // (4+2)>>1=3 clamps to 4
        strobe(256);

        // diff_in = 0 saturates to 255; th -> (4+127)>>1 = 65
        flat(50);
        strobe(0);
        check("sat_peak", int'(state), S_PEAK);
        expect_evt(1'b0, 255, 321, 191, 1'b1, 52);
        strobe(256);
        check("sat_vth_p", int'(vth_p), 321);

        // Async reset while in PEAK
        flat(50);
        strobe(400);
        check("pre_reset_peak", int'(state), S_PEAK);
        #2 rst = 1'b0;
        #1;
        check("async_rst_state",    int'(state),       S_IDLE);
        check("async_rst_vth_p",    int'(vth_p),       264);
        check("async_rst_vth_n",    int'(vth_n),       248);
        check("async_rst_peak_mag", int'(peak_mag),    0);
        check("async_rst_rr",       int'(rr_interval), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_armed", int'(state), S_ARMED);

        // en=0 on the committing strobe: no beat, IDLE
        strobe(300);
        check("en_test_peak", int'(state), S_PEAK);
        en = 1'b0;
        strobe(256);
        check("en_wins_state", int'(state), S_IDLE);
        check("en_wins_beat",  int'(beat),  0);
        check("en_th_kept",    int'(vth_p), 264);
        en = 1'b1;
        @(negedge clk);
        check("re_enable_armed", int'(state), S_ARMED);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
